// File: rtl/gate_op_arbiter_if.sv
// rtl/gate_op_arbiter_if.sv - request/operand/response bundle between two requesters and the gate-op arbiter
interface gate_op_arbiter_if #(
  parameter int WIDTH = 8
) ();
  logic [1:0]       req_i;
  logic [2:0]       op0_i;
  logic [2:0]       op1_i;
  logic [WIDTH-1:0] a0_i;
  logic [WIDTH-1:0] b0_i;
  logic [WIDTH-1:0] a1_i;
  logic [WIDTH-1:0] b1_i;
  logic [1:0]       gnt_o;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic             rsp_id_o;
  logic [WIDTH-1:0] y_o;
  logic             err_o;

  modport master (
    output req_i, op0_i, op1_i, a0_i, b0_i, a1_i, b1_i, rsp_ready_i,
    input  gnt_o, rsp_valid_o, rsp_id_o, y_o, err_o
  );

  modport slave (
    input  req_i, op0_i, op1_i, a0_i, b0_i, a1_i, b1_i, rsp_ready_i,
    output gnt_o, rsp_valid_o, rsp_id_o, y_o, err_o
  );
endinterface

// File: rtl/gate_op_arbiter.sv
// rtl/gate_op_arbiter.sv - two-requester arbiter feeding a registered bitwise gate unit
// GATE_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties) instead of round-robin.
module gate_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_op_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic [1:0]       r_gnt;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_y;
  logic             r_err;

  logic             w_win;
  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_y;
  logic             w_err;

`ifdef GATE_ARB_FIXED_PRIO_EN
  assign w_win = ~bus.req_i[0];
`else
  // r_last holds the index granted most recently; a tie goes to the other one
  logic r_last;
  assign w_win = (bus.req_i == 2'b11) ? ~r_last : bus.req_i[1];
`endif

  assign w_op = w_win ? bus.op1_i : bus.op0_i;
  assign w_a  = w_win ? bus.a1_i  : bus.a0_i;
  assign w_b  = w_win ? bus.b1_i  : bus.b0_i;

  always_comb begin
    w_y   = '0;
    w_err = 1'b0;
    case (r_op)
      3'd0:    w_y = r_a & r_b;
      3'd1:    w_y = r_a | r_b;
      3'd2:    w_y = ~r_a;
      3'd3:    w_y = ~(r_a & r_b);
      3'd4:    w_y = ~(r_a | r_b);
      3'd5:    w_y = r_a ^ r_b;
      3'd6:    w_y = ~(r_a ^ r_b);
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_gnt       <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_y         <= '0;
      r_err       <= 1'b0;
`ifndef GATE_ARB_FIXED_PRIO_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_gnt <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|bus.req_i) begin
            r_op    <= w_op;
            r_a     <= w_a;
            r_b     <= w_b;
            r_id    <= w_win;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
`ifndef GATE_ARB_FIXED_PRIO_EN
            r_last  <= w_win;
`endif
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_y         <= w_y;
          r_err       <= w_err;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt_o       = r_gnt;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_id_o    = r_rsp_id;
  assign bus.y_o         = r_y;
  assign bus.err_o       = r_err;
endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb/tb_gate_op_arbiter.sv - directed and random checks of gate_op_arbiter against a transaction-level model
module tb_gate_op_arbiter;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  gate_op_arbiter_if #(.WIDTH(8)) bus ();

  gate_op_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Each opcode as a 4-entry truth table indexed by {a_bit, b_bit}
  function automatic logic [7:0] ref_y(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [3:0] tt;
    logic [7:0] y;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0011;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b0110;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b0000;
    endcase
    for (int k = 0; k < 8; k++) y[k] = tt[{a[k], b[k]}];
    return y;
  endfunction

  function automatic logic pick(input logic [1:0] rq, input logic last);
`ifdef GATE_ARB_FIXED_PRIO_EN
    return rq[0] ? 1'b0 : 1'b1;
`else
    if (rq == 2'b01) return 1'b0;
    if (rq == 2'b10) return 1'b1;
    return !last;
`endif
  endfunction

  logic       m_busy;
  logic       m_valid;
  logic       m_last;
  logic [1:0] m_exp_gnt;
  logic       m_id;
  logic [7:0] m_y;
  logic       m_err;

  // Transaction-level model: one job at a time, result one edge after the grant
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_last <= 1'b1;
      m_exp_gnt <= 2'b00; m_id <= 1'b0; m_y <= 8'h00; m_err <= 1'b0;
    end else begin
      m_exp_gnt <= 2'b00;
      if (m_busy && m_valid) begin
        if (bus.rsp_ready_i) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b0;
        end
      end else if (m_busy) begin
        m_valid <= 1'b1;
      end else if (bus.req_i != 2'b00) begin
        m_busy    <= 1'b1;
        m_last    <= pick(bus.req_i, m_last);
        m_id      <= pick(bus.req_i, m_last);
        m_exp_gnt <= pick(bus.req_i, m_last) ? 2'b10 : 2'b01;
        m_y       <= pick(bus.req_i, m_last) ? ref_y(bus.op1_i, bus.a1_i, bus.b1_i)
                                             : ref_y(bus.op0_i, bus.a0_i, bus.b0_i);
        m_err     <= (pick(bus.req_i, m_last) ? bus.op1_i : bus.op0_i) == 3'd7;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst gnt", 32'(bus.gnt_o), 32'd0);
      check("rst valid", 32'(bus.rsp_valid_o), 32'd0);
      check("rst y", 32'(bus.y_o), 32'd0);
    end else begin
      check("mdl gnt", 32'(bus.gnt_o), 32'(m_exp_gnt));
      check("mdl valid", 32'(bus.rsp_valid_o), 32'(m_valid));
      if (m_valid) begin
        check("mdl y", 32'(bus.y_o), 32'(m_y));
        check("mdl err", 32'(bus.err_o), 32'(m_err));
        check("mdl id", 32'(bus.rsp_id_o), 32'(m_id));
      end
    end
  end

  task automatic scramble();
    bus.op0_i = 3'($urandom); bus.a0_i = 8'($urandom); bus.b0_i = 8'($urandom);
    bus.op1_i = 3'($urandom); bus.a1_i = 8'($urandom); bus.b1_i = 8'($urandom);
  endtask

  task automatic txn(input logic [1:0] rq, input int hold, input logic [1:0] eg,
                     input logic [7:0] ey, input logic ee, input logic eid, input string nm);
    int n;
    bus.req_i = rq;
    bus.rsp_ready_i = (hold == 0);
    n = 0;
    @(negedge clk);
    while (bus.gnt_o == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, " gnt"}, 32'(bus.gnt_o), 32'(eg));
    @(posedge clk); #1;
    bus.req_i = 2'b00;
    scramble();
    @(negedge clk);
    check({nm, " valid"}, 32'(bus.rsp_valid_o), 32'd1);
    check({nm, " y"}, 32'(bus.y_o), 32'(ey));
    check({nm, " err"}, 32'(bus.err_o), 32'(ee));
    check({nm, " id"}, 32'(bus.rsp_id_o), 32'(eid));
    for (int c = 1; c < hold; c++) begin
      @(posedge clk); #1;
      bus.req_i = 2'b11;
      @(negedge clk);
      check({nm, " hold valid"}, 32'(bus.rsp_valid_o), 32'd1);
      check({nm, " hold y"}, 32'(bus.y_o), 32'(ey));
      check({nm, " hold gnt"}, 32'(bus.gnt_o), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      bus.req_i = 2'b00;
      bus.rsp_ready_i = 1'b1;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, " valid clr"}, 32'(bus.rsp_valid_o), 32'd0);
  endtask

  task automatic set_tie_ops();
    bus.op0_i = 3'd5; bus.a0_i = 8'hAA; bus.b0_i = 8'h0F;
    bus.op1_i = 3'd6; bus.a1_i = 8'hAA; bus.b1_i = 8'h0F;
  endtask

  initial begin
    logic [1:0] g;
    int n;
    rst_n = 1'b0;
    bus.req_i = 2'b00;
    bus.rsp_ready_i = 1'b1;
    scramble();

    check("ref and", 32'(ref_y(3'd0, 8'hF0, 8'h3C)), 32'h30);
    check("ref xor", 32'(ref_y(3'd5, 8'hAA, 8'h0F)), 32'hA5);
    check("ref xnor", 32'(ref_y(3'd6, 8'hAA, 8'h0F)), 32'h5A);
    check("ref not", 32'(ref_y(3'd2, 8'h81, 8'h55)), 32'h7E);
    check("ref rsvd", 32'(ref_y(3'd7, 8'hFF, 8'hFF)), 32'h00);

    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    set_tie_ops();
    txn(2'b11, 0, 2'b01, 8'hA5, 1'b0, 1'b0, "tie1");
    set_tie_ops();
`ifdef GATE_ARB_FIXED_PRIO_EN
    txn(2'b11, 0, 2'b01, 8'hA5, 1'b0, 1'b0, "tie2");
    set_tie_ops();
    txn(2'b11, 0, 2'b01, 8'hA5, 1'b0, 1'b0, "tie3");
`else
    txn(2'b11, 0, 2'b10, 8'h5A, 1'b0, 1'b1, "tie2");
`endif

    bus.op0_i = 3'd0; bus.a0_i = 8'hF0; bus.b0_i = 8'h3C;
    txn(2'b01, 0, 2'b01, 8'h30, 1'b0, 1'b0, "single");

    bus.op1_i = 3'd2; bus.a1_i = 8'h81; bus.b1_i = 8'($urandom);
    txn(2'b10, 5, 2'b10, 8'h7E, 1'b0, 1'b1, "bp");

    bus.op1_i = 3'd7; bus.a1_i = 8'hFF; bus.b1_i = 8'h00;
    txn(2'b10, 0, 2'b10, 8'h00, 1'b1, 1'b1, "rsvd");

    // Reset while the granted job is in EXEC
    bus.op0_i = 3'd1; bus.a0_i = 8'h12; bus.b0_i = 8'h34;
    bus.req_i = 2'b01;
    n = 0;
    @(negedge clk);
    while (bus.gnt_o == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstx gnt", 32'(bus.gnt_o), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rstx gnt0", 32'(bus.gnt_o), 32'd0);
    check("rstx valid0", 32'(bus.rsp_valid_o), 32'd0);
    check("rstx y0", 32'(bus.y_o), 32'd0);
    check("rstx err0", 32'(bus.err_o), 32'd0);
    check("rstx id0", 32'(bus.rsp_id_o), 32'd0);
    bus.req_i = 2'b00;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstx no rsp", 32'(bus.rsp_valid_o), 32'd0);
    end
    set_tie_ops();
    txn(2'b11, 0, 2'b01, 8'hA5, 1'b0, 1'b0, "post rst tie");

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      g = bus.gnt_o;
      if (g[0] || !bus.req_i[0]) begin
        bus.op0_i = 3'($urandom); bus.a0_i = 8'($urandom); bus.b0_i = 8'($urandom);
      end
      if (g[1] || !bus.req_i[1]) begin
        bus.op1_i = 3'($urandom); bus.a1_i = 8'($urandom); bus.b1_i = 8'($urandom);
      end
      if (g[0]) bus.req_i[0] = ($urandom % 4 == 0);
      else if (!bus.req_i[0]) bus.req_i[0] = ($urandom % 3 == 0);
      if (g[1]) bus.req_i[1] = ($urandom % 4 == 0);
      else if (!bus.req_i[1]) bus.req_i[1] = ($urandom % 3 == 0);
      bus.rsp_ready_i = ($urandom % 3 != 0);
    end

    bus.req_i = 2'b00;
    bus.rsp_ready_i = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain idle", 32'(bus.rsp_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gate_op_arbiter.md
GATE_OP_ARBITER -- requirements
Module: gate_op_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_i  input  2  per-requester request; bit i belongs to requester i, held high until granted.
REQ-005 op0_i, op1_i  input  3 each  operation code of requester 0 and 1.
REQ-006 a0_i, b0_i, a1_i, b1_i  input  WIDTH each  operands of requester 0 and 1.
REQ-007 gnt_o  output  2  one-hot grant, high for exactly one cycle per accepted request.
REQ-008 rsp_valid_o  output  1  result available.
REQ-009 rsp_ready_i  input  1  consumer accepts the result.
REQ-010 rsp_id_o  output  1  index of the requester that owns the result.
REQ-011 y_o  output  WIDTH  bitwise gate result.
REQ-012 err_o  output  1  reserved opcode flag, qualified by rsp_valid_o.

Function
REQ-013 Opcode map, bitwise over WIDTH: 0 AND, 1 OR, 2 NOT a (b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
REQ-014 Reserved opcode 7: y_o = 0 and err_o = 1; all other opcodes give err_o = 0.
REQ-015 FSM states are IDLE, EXEC and DONE; reset state is IDLE.
REQ-016 IDLE with req_i != 0 at a clock edge: arbitrate, latch the winner's op/a/b and index, pulse gnt_o for the next cycle, go to EXEC.
REQ-017 req_i is sampled only in IDLE; requests raised during EXEC or DONE wait.
REQ-018 EXEC: at the next edge, register y_o/err_o from the latched operands, set rsp_valid_o = 1, go to DONE.
REQ-019 DONE: hold rsp_valid_o, y_o, err_o and rsp_id_o stable until an edge with rsp_ready_i = 1; then clear rsp_valid_o and go to IDLE.
REQ-020 Latency: result is valid two cycles after the accepting edge; minimum 3 cycles per transaction; no overlapping transactions.
REQ-021 Round-robin: a single requesting bit wins outright; if both bits request, the requester not granted last wins; after reset, requester 0 wins the first tie.
REQ-022 The last-grant pointer updates on each accepting edge.
REQ-023 Operand changes after the accepting edge do not affect the result in flight.
REQ-024 Requesters drop req_i the cycle after seeing gnt_o; a still-high req_i in the next IDLE is treated as a new request.

Reset
REQ-025 Assertion of rst_n = 0 immediately forces: state IDLE; gnt_o = 0, rsp_valid_o = 0, rsp_id_o = 0, y_o = 0, err_o = 0; last-grant pointer = 1 (requester 0 favoured).
REQ-026 Reset mid-transaction discards the in-flight result without any response.
REQ-027 Deassertion is taken on the next clock edge; the first request may be accepted on the first edge with rst_n = 1.

Configuration
REQ-028 Macro GATE_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties, and the last-grant pointer is not implemented.
REQ-029 Macro GATE_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-021; all other behaviour is identical in both builds.

Verification
REQ-030 Single request: req_i=01, op0=0, a0=8'hF0, b0=8'h3C, rsp_ready=1 -> gnt_o=01 one cycle, two cycles later y_o=8'h30, rsp_id_o=0, err_o=0.
REQ-031 Tie round-robin: req_i=11 held over two transactions, op0=5, op1=6, a=8'hAA, b=8'h0F -> first grant 01 with y=8'hA5, second grant 10 with y=8'h5A.
REQ-032 Back-pressure: rsp_ready=0 for 5 cycles with NOT a1=8'h81 -> y_o=8'h7E and rsp_valid_o held stable for 5 cycles; no gnt_o while waiting.
REQ-033 Reserved opcode: op1=7, a1=8'hFF -> y_o=8'h00, err_o=1, rsp_id_o=1.
REQ-034 Reset in EXEC: rst_n pulsed low -> all outputs 0 immediately, no rsp_valid_o afterwards; the next tie is granted to requester 0.
REQ-035 With GATE_ARB_FIXED_PRIO_EN defined: req_i=11 held for 3 transactions -> gnt_o=01 each time.
